// File: rtl/output_pipeline.sv
// rtl/output_pipeline.sv - result SRAM to frame SRAM pixel packer (optional OUTPUT_ROUND_EN rounding)
module output_pipeline #(
  parameter int N_IN      = 256,
  parameter int FRAC_BITS = 8
) (
  input  logic         clock,
  input  logic         rst_n,
  input  logic         start,
  input  logic         outputBaseOffset,
  output logic [15:0]  m4ReadAddr,
  input  logic [127:0] m4ReadBus,
  output logic [15:0]  m1WriteAddr,
  output logic [127:0] m1WriteBus,
  output logic         m1WE,
  output logic         done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [15:0] LAST_ADDR = 16'(N_IN - 1);

  logic [1:0]  state;
  logic [15:0] base_addr;
  logic [15:0] wr_idx;
  logic        rd_pend;
  logic        rd_odd;
  logic [63:0] hold;
  logic [63:0] pix_now;
  logic        run_entry;
  logic        cap;

  // One signed Q-format sample to a saturated 8-bit pixel; the 17-bit
  // working width keeps the rounding add from wrapping before the clamp.
  function automatic logic [7:0] to_pixel(input logic [15:0] s);
    logic signed [16:0] w;
    logic signed [16:0] v;
    w = signed'({s[15], s});
`ifdef OUTPUT_ROUND_EN
    w = w + (17'sd1 <<< (FRAC_BITS - 1));
`endif
    v = w >>> FRAC_BITS;
    if (v < 17'sd0) begin
      return 8'h00;
    end else if (v > 17'sd255) begin
      return 8'hFF;
    end else begin
      return v[7:0];
    end
  endfunction

  assign run_entry = (state == S_IDLE) && start;
  // A returning read is only used while the run is still requested, so an
  // abort discards whatever is in flight on the same edge.
  assign cap       = rd_pend && start;

  // Convert all eight lanes of the word currently on the read bus.
  always_comb begin
    pix_now = '0;
    for (int j = 0; j < 8; j++) begin
      pix_now[8*j +: 8] = to_pixel(m4ReadBus[16*j +: 16]);
    end
  end

  // Frame sequencing; dropping start leaves any active state for IDLE.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (start) state <= S_RUN;
        S_RUN: begin
          if (!start)                        state <= S_IDLE;
          else if (m4ReadAddr == LAST_ADDR)  state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (!start)                        state <= S_IDLE;
          else if (m1WE && !rd_pend)         state <= S_DONE;
        end
        S_DONE:  if (!start) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Read address: zeroed on run entry, stepped once per RUN cycle, held otherwise.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      m4ReadAddr <= 16'h0000;
    end else if (run_entry) begin
      m4ReadAddr <= 16'h0000;
    end else if ((state == S_RUN) && start && (m4ReadAddr != LAST_ADDR)) begin
      m4ReadAddr <= m4ReadAddr + 16'h0001;
    end
  end

  // Track which issued address has its data on the bus next cycle, and its parity.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend <= 1'b0;
      rd_odd  <= 1'b0;
    end else begin
      rd_pend <= (state == S_RUN) && start;
      rd_odd  <= m4ReadAddr[0];
    end
  end

  // Latch the destination base and restart the output word count on run entry.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      base_addr <= 16'h0000;
    end else if (run_entry) begin
      base_addr <= outputBaseOffset ? 16'h8000 : 16'h0000;
    end
  end

  // Pair even/odd words: even word parks in hold, odd word triggers one write.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      hold        <= '0;
      wr_idx      <= 16'h0000;
      m1WE        <= 1'b0;
      m1WriteAddr <= 16'h0000;
      m1WriteBus  <= '0;
    end else begin
      m1WE <= cap && rd_odd;
      if (run_entry) begin
        hold   <= '0;
        wr_idx <= 16'h0000;
      end else if (cap && !rd_odd) begin
        hold <= pix_now;
      end else if (cap && rd_odd) begin
        m1WriteBus  <= {pix_now, hold};
        m1WriteAddr <= base_addr + wr_idx;
        wr_idx      <= wr_idx + 16'h0001;
      end
    end
  end

  // done rises with the DONE state and falls as soon as start is released.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      done <= 1'b0;
    end else begin
      done <= start && (((state == S_DRAIN) && m1WE && !rd_pend) || (state == S_DONE));
    end
  end

endmodule

// File: tb/tb_output_pipeline.sv
// tb/tb_output_pipeline.sv - directed self-checking bench for output_pipeline
module tb_output_pipeline;

  localparam int N = 4;

  localparam logic [127:0] W_T1    = {8{16'h0A80}};
  localparam logic [127:0] W_SAT   = 128'h8000_0000_0080_FFFF_0FF0_1000_7FFF_FF00;
  localparam logic [127:0] W_PK0   = 128'h0800_0700_0600_0500_0400_0300_0200_0100;
  localparam logic [127:0] W_PK1   = 128'h1000_0F00_0E00_0D00_0C00_0B00_0A00_0900;
  localparam logic [127:0] EXP_PK  = 128'h100F0E0D0C0B0A09_0807060504030201;
  localparam logic [127:0] EXP_S4  = {2{64'h00000800_FFFFFF00}};
`ifdef OUTPUT_ROUND_EN
  localparam logic [127:0] EXP_T1  = {16{8'h0B}};
  localparam logic [127:0] EXP_S8  = {2{64'h00000100_10108000}};
`else
  localparam logic [127:0] EXP_T1  = {16{8'h0A}};
  localparam logic [127:0] EXP_S8  = {2{64'h00000000_0F107F00}};
`endif

  logic         clock = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         outputBaseOffset = 1'b0;
  logic [15:0]  m4ReadAddr, m1WriteAddr, m4ReadAddr2, m1WriteAddr2;
  logic [127:0] m4ReadBus, m1WriteBus, m1WriteBus2;
  logic         m1WE, done, m1WE2, done2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [127:0] mem [0:3];
  logic [15:0]  wa_q [$];
  logic [127:0] wb_q [$];
  int           wc_q [$];
  logic [127:0] wb2_q [$];
  int           dn_q [$];
  logic         done_d = 1'b0;

  output_pipeline #(.N_IN(N), .FRAC_BITS(8)) dut (
    .clock(clock), .rst_n(rst_n), .start(start), .outputBaseOffset(outputBaseOffset),
    .m4ReadAddr(m4ReadAddr), .m4ReadBus(m4ReadBus), .m1WriteAddr(m1WriteAddr),
    .m1WriteBus(m1WriteBus), .m1WE(m1WE), .done(done));

  output_pipeline #(.N_IN(N), .FRAC_BITS(4)) dut4 (
    .clock(clock), .rst_n(rst_n), .start(start), .outputBaseOffset(outputBaseOffset),
    .m4ReadAddr(m4ReadAddr2), .m4ReadBus(m4ReadBus), .m1WriteAddr(m1WriteAddr2),
    .m1WriteBus(m1WriteBus2), .m1WE(m1WE2), .done(done2));

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(posedge clock) m4ReadBus <= mem[m4ReadAddr[1:0]];

  always @(negedge clock) begin
    if (m1WE) begin
      wa_q.push_back(m1WriteAddr);
      wb_q.push_back(m1WriteBus);
      wc_q.push_back(cyc);
    end
    if (m1WE2) wb2_q.push_back(m1WriteBus2);
    if (done && !done_d) dn_q.push_back(cyc);
    done_d = done;
  end

  task automatic load_mem(input logic [127:0] w0, input logic [127:0] w1);
    mem[0] = w0; mem[1] = w1; mem[2] = w0; mem[3] = w1;
  endtask

  task automatic run_frame(input logic base, output int e0, output int wi, output int w2i,
                           output int di, output bit ok);
    @(negedge clock);
    wi = wa_q.size(); w2i = wb2_q.size(); di = dn_q.size();
    outputBaseOffset = base;
    start = 1'b1;
    e0 = cyc + 1;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clock);
      if (i == 0) outputBaseOffset = ~base;
      if (done) ok = 1'b1;
    end
  endtask

  task automatic stop_run();
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    @(negedge clock);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clock);
    @(negedge clock);
    checks++; if (m4ReadAddr !== 16'h0) begin errors++; $display("FAIL rst_raddr: got %h expected 0000", m4ReadAddr); end
    checks++; if (m1WriteAddr !== 16'h0) begin errors++; $display("FAIL rst_waddr: got %h expected 0000", m1WriteAddr); end
    checks++; if (m1WriteBus !== 128'h0) begin errors++; $display("FAIL rst_wbus: got %h expected 0", m1WriteBus); end
    checks++; if (m1WE !== 1'b0) begin errors++; $display("FAIL rst_we: got %b expected 0", m1WE); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b expected 0", done); end
    rst_n = 1'b1;
  endtask

  task automatic test_truncate();
    int e0, wi, w2i, di; bit ok;
    load_mem(W_T1, W_T1);
    run_frame(1'b0, e0, wi, w2i, di, ok);
    checks++; if (!ok) begin errors++; $display("FAIL t1_timeout: done not seen within 40 cycles"); end
    checks++; if (wa_q.size() - wi !== 2) begin errors++; $display("FAIL t1_nwrites: got %0d expected 2", wa_q.size() - wi); end
    if (wa_q.size() >= wi + 2 && dn_q.size() > di) begin
      checks++; if (wa_q[wi] !== 16'h0000) begin errors++; $display("FAIL t1_addr0: got %h expected 0000", wa_q[wi]); end
      checks++; if (wa_q[wi+1] !== 16'h0001) begin errors++; $display("FAIL t1_addr1: got %h expected 0001", wa_q[wi+1]); end
      checks++; if (wb_q[wi] !== EXP_T1) begin errors++; $display("FAIL t1_bus0: got %h expected %h", wb_q[wi], EXP_T1); end
      checks++; if (wb_q[wi+1] !== EXP_T1) begin errors++; $display("FAIL t1_bus1: got %h expected %h", wb_q[wi+1], EXP_T1); end
      checks++; if (wc_q[wi] !== e0 + 3) begin errors++; $display("FAIL t1_first_we: got cycle %0d expected %0d", wc_q[wi], e0 + 3); end
      checks++; if (wc_q[wi+1] !== e0 + 5) begin errors++; $display("FAIL t1_last_we: got cycle %0d expected %0d", wc_q[wi+1], e0 + 5); end
      checks++; if (dn_q[di] !== e0 + 6) begin errors++; $display("FAIL t1_done_cyc: got cycle %0d expected %0d", dn_q[di], e0 + 6); end
    end
    repeat (5) @(negedge clock);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL t1_done_held: got %b expected 1", done); end
    checks++; if (wa_q.size() - wi !== 2) begin errors++; $display("FAIL t1_extra_writes: got %0d expected 2", wa_q.size() - wi); end
    stop_run();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL t1_done_clear: got %b expected 0", done); end
  endtask

  task automatic test_saturation();
    int e0, wi, w2i, di; bit ok;
    load_mem(W_SAT, W_SAT);
    run_frame(1'b0, e0, wi, w2i, di, ok);
    checks++; if (!ok) begin errors++; $display("FAIL sat_timeout: done not seen within 40 cycles"); end
    if (wb_q.size() > wi && wb2_q.size() > w2i) begin
      checks++; if (wb_q[wi] !== EXP_S8) begin errors++; $display("FAIL sat_q8: got %h expected %h", wb_q[wi], EXP_S8); end
      checks++; if (wb2_q[w2i] !== EXP_S4) begin errors++; $display("FAIL sat_q4: got %h expected %h", wb2_q[w2i], EXP_S4); end
    end
    stop_run();
  endtask

  task automatic test_base_offset();
    int e0, wi, w2i, di; bit ok;
    load_mem(W_T1, W_T1);
    run_frame(1'b1, e0, wi, w2i, di, ok);
    checks++; if (!ok) begin errors++; $display("FAIL base_timeout: done not seen within 40 cycles"); end
    if (wa_q.size() >= wi + 2 && dn_q.size() > di) begin
      checks++; if (wa_q[wi] !== 16'h8000) begin errors++; $display("FAIL base_addr0: got %h expected 8000", wa_q[wi]); end
      checks++; if (wa_q[wi+1] !== 16'h8001) begin errors++; $display("FAIL base_addr1: got %h expected 8001", wa_q[wi+1]); end
      checks++; if (wc_q[wi] !== e0 + 3) begin errors++; $display("FAIL base_first_we: got cycle %0d expected %0d", wc_q[wi], e0 + 3); end
      checks++; if (dn_q[di] !== e0 + 6) begin errors++; $display("FAIL base_done_cyc: got cycle %0d expected %0d", dn_q[di], e0 + 6); end
    end
    stop_run();
  endtask

  task automatic test_packing();
    int e0, wi, w2i, di; bit ok;
    load_mem(W_PK0, W_PK1);
    run_frame(1'b0, e0, wi, w2i, di, ok);
    checks++; if (!ok) begin errors++; $display("FAIL pack_timeout: done not seen within 40 cycles"); end
    if (wb_q.size() >= wi + 2) begin
      checks++; if (wb_q[wi] !== EXP_PK) begin errors++; $display("FAIL pack_bus0: got %h expected %h", wb_q[wi], EXP_PK); end
      checks++; if (wb_q[wi+1] !== EXP_PK) begin errors++; $display("FAIL pack_bus1: got %h expected %h", wb_q[wi+1], EXP_PK); end
    end
    stop_run();
  endtask

  task automatic test_abort();
    int e0, wi, w2i, di; bit ok;
    load_mem(W_PK0, W_PK1);
    @(negedge clock);
    wi = wa_q.size(); di = dn_q.size();
    outputBaseOffset = 1'b0;
    start = 1'b1;
    @(negedge clock);
    @(negedge clock);
    start = 1'b0;
    repeat (8) @(negedge clock);
    checks++; if (wa_q.size() !== wi) begin errors++; $display("FAIL abort_writes: got %0d expected 0", wa_q.size() - wi); end
    checks++; if (dn_q.size() !== di || done !== 1'b0) begin errors++; $display("FAIL abort_done: got %b expected 0", done); end
    checks++; if (m4ReadAddr !== 16'h0001) begin errors++; $display("FAIL abort_raddr_hold: got %h expected 0001", m4ReadAddr); end
    run_frame(1'b0, e0, wi, w2i, di, ok);
    checks++; if (!ok) begin errors++; $display("FAIL restart_timeout: done not seen within 40 cycles"); end
    checks++; if (wa_q.size() - wi !== 2) begin errors++; $display("FAIL restart_nwrites: got %0d expected 2", wa_q.size() - wi); end
    if (wa_q.size() >= wi + 2) begin
      checks++; if (wa_q[wi] !== 16'h0000) begin errors++; $display("FAIL restart_addr0: got %h expected 0000", wa_q[wi]); end
      checks++; if (wb_q[wi+1] !== EXP_PK) begin errors++; $display("FAIL restart_bus1: got %h expected %h", wb_q[wi+1], EXP_PK); end
    end
    stop_run();
  endtask

  task automatic test_async_reset();
    int e0, wi, di; bit ok;
    load_mem(W_T1, W_T1);
    @(negedge clock);
    wi = wa_q.size();
    outputBaseOffset = 1'b1;
    start = 1'b1;
    repeat (5) @(negedge clock);
    checks++; if (m1WriteAddr !== 16'h8000) begin errors++; $display("FAIL ar_pre_waddr: got %h expected 8000", m1WriteAddr); end
    rst_n = 1'b0;
    #1;
    checks++; if (m4ReadAddr !== 16'h0) begin errors++; $display("FAIL ar_raddr: got %h expected 0000", m4ReadAddr); end
    checks++; if (m1WriteAddr !== 16'h0) begin errors++; $display("FAIL ar_waddr: got %h expected 0000", m1WriteAddr); end
    checks++; if (m1WriteBus !== 128'h0) begin errors++; $display("FAIL ar_wbus: got %h expected 0", m1WriteBus); end
    checks++; if (m1WE !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL ar_we_done: got %b%b expected 00", m1WE, done); end
    @(negedge clock);
    @(negedge clock);
    checks++; if (wa_q.size() - wi !== 1) begin errors++; $display("FAIL ar_partial: got %0d writes expected 1", wa_q.size() - wi); end
    @(negedge clock);
    wi = wa_q.size(); di = dn_q.size();
    outputBaseOffset = 1'b0;
    rst_n = 1'b1;
    e0 = cyc + 1;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clock);
      if (done) ok = 1'b1;
    end
    checks++; if (!ok) begin errors++; $display("FAIL ar_rerun_timeout: done not seen within 40 cycles"); end
    checks++; if (wa_q.size() - wi !== 2) begin errors++; $display("FAIL ar_rerun_nwrites: got %0d expected 2", wa_q.size() - wi); end
    if (wa_q.size() >= wi + 2) begin
      checks++; if (wa_q[wi] !== 16'h0000) begin errors++; $display("FAIL ar_rerun_addr0: got %h expected 0000", wa_q[wi]); end
      checks++; if (wc_q[wi] !== e0 + 3) begin errors++; $display("FAIL ar_rerun_first_we: got cycle %0d expected %0d", wc_q[wi], e0 + 3); end
      checks++; if (wb_q[wi] !== EXP_T1) begin errors++; $display("FAIL ar_rerun_bus0: got %h expected %h", wb_q[wi], EXP_T1); end
    end
    stop_run();
  endtask

  initial begin
    load_mem(128'h0, 128'h0);
    test_reset();
    test_truncate();
    test_saturation();
    test_base_offset();
    test_packing();
    test_abort();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 time units");
    $fatal(1);
  end

endmodule
